// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with valid/ready on both sides and first/last bit markers.
// A one-word holding buffer lets consecutive words stream with no idle bit between them.
module par2ser_stream #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_first,
  output logic              dout_last,
  output logic              busy
);

  // state | meaning
  // IDLE  | shifter empty, no bit on dout
  // SHIFT | shifter holds a word, cnt indexes the bit on dout
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic [CNT_W-1:0]  cnt;

  logic              sh_valid;
  logic              accept;
  logic              xfer;
  logic              cnt_last;
  logic [DATA_W-1:0] sh_shifted;

  assign sh_valid  = (state == SHIFT);
  assign din_ready = !hold_valid;
  assign accept    = din_valid && din_ready;
  assign xfer      = sh_valid && dout_ready;
  assign cnt_last  = (cnt == CNT_W'(DATA_W - 1));

  // Shift toward whichever end feeds dout.
  assign sh_shifted = LSB_FIRST ? {1'b0, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], 1'b0};

  assign dout_valid = sh_valid;
  assign dout       = sh_valid && (LSB_FIRST ? sh[0] : sh[DATA_W-1]);
  assign dout_first = sh_valid && (cnt == '0);
  assign dout_last  = sh_valid && cnt_last;
  assign busy       = sh_valid || hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh    <= din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer && cnt_last) begin
            // Reload priority: held word first, then a word arriving now.
            if (hold_valid) begin
              sh         <= hold;
              hold_valid <= 1'b0;
              cnt        <= '0;
            end else if (accept) begin
              sh  <= din;
              cnt <= '0;
            end else begin
              sh    <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            if (xfer) begin
              sh  <= sh_shifted;
              cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
              hold       <= din;
              hold_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_par2ser_stream.sv
// Scoreboard bench for par2ser_stream: four instances (8 MSB, 8 LSB, 4 MSB, 2 MSB) driven
// by directed words; expected bit streams are pushed on issue and popped by a monitor.
module tb_par2ser_stream;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din_a [4];
  logic        v_a   [4];
  logic        rdy_a [4];
  logic        dr_a  [4];
  logic        dv_a  [4];
  logic        dd_a  [4];
  logic        df_a  [4];
  logic        dl_a  [4];
  logic        bz_a  [4];

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  par2ser_stream #(.DATA_W(8), .LSB_FIRST(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din_a[0][7:0]), .din_valid(v_a[0]), .din_ready(dr_a[0]),
    .dout(dd_a[0]), .dout_valid(dv_a[0]), .dout_ready(rdy_a[0]), .dout_first(df_a[0]),
    .dout_last(dl_a[0]), .busy(bz_a[0]));

  par2ser_stream #(.DATA_W(8), .LSB_FIRST(1'b1)) u8l (
    .clk(clk), .rst_n(rst_n), .din(din_a[1][7:0]), .din_valid(v_a[1]), .din_ready(dr_a[1]),
    .dout(dd_a[1]), .dout_valid(dv_a[1]), .dout_ready(rdy_a[1]), .dout_first(df_a[1]),
    .dout_last(dl_a[1]), .busy(bz_a[1]));

  par2ser_stream #(.DATA_W(4), .LSB_FIRST(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din_a[2][3:0]), .din_valid(v_a[2]), .din_ready(dr_a[2]),
    .dout(dd_a[2]), .dout_valid(dv_a[2]), .dout_ready(rdy_a[2]), .dout_first(df_a[2]),
    .dout_last(dl_a[2]), .busy(bz_a[2]));

  par2ser_stream #(.DATA_W(2), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din_a[3][1:0]), .din_valid(v_a[3]), .din_ready(dr_a[3]),
    .dout(dd_a[3]), .dout_valid(dv_a[3]), .dout_ready(rdy_a[3]), .dout_first(df_a[3]),
    .dout_last(dl_a[3]), .busy(bz_a[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // seq holds the bits in transmission order, first bit at seq[n-1].
  task automatic push_seq(input int inst, input logic [63:0] seq, input int n, input int w);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = seq[n-1-i];
      e.f = ((i % w) == 0);
      e.l = ((i % w) == w - 1);
      case (inst)
        0: q0.push_back(e);
        1: q1.push_back(e);
        2: q2.push_back(e);
        default: q3.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int inst);
    exp_t e;
    int   sz;
    case (inst)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = q3.size();
    endcase
    if (sz == 0) begin
      check($sformatf("unexpected_bit_%0d", inst), 64'd1, 64'd0);
    end else begin
      case (inst)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      check($sformatf("bit_dfl_%0d", inst), {61'd0, dd_a[inst], df_a[inst], dl_a[inst]},
            {61'd0, e.b, e.f, e.l});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        if (dv_a[i] && rdy_a[i]) mon(i);
    end
  end

  // Offer a word and wait (bounded) until it is accepted; returns #1 after the accepting edge.
  task automatic send(input int inst, input logic [63:0] word);
    bit done;
    done = 1'b0;
    din_a[inst] = word;
    v_a[inst]   = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (dr_a[inst]) done = 1'b1;
      cyc();
    end
    v_a[inst] = 1'b0;
    if (!done) check($sformatf("send_timeout_%0d", inst), 64'd0, 64'd1);
  endtask

  logic [1:0] u2_din [8] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  logic       u2_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       u2_dr  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       u2_dv  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 4; i++) begin
      din_a[i] = '0;
      v_a[i]   = 1'b0;
      rdy_a[i] = 1'b1;
    end

    // Reset state, observed while rst_n is still low.
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_outs_%0d", i),
            {59'd0, dv_a[i], dd_a[i], df_a[i], dl_a[i], bz_a[i]}, 64'd0);
      check($sformatf("rst_din_ready_%0d", i), {63'd0, dr_a[i]}, 64'd1);
    end
    cyc();
    rst_n = 1'b1;
    cyc();

    // 8'hA5 MSB-first: bits on cycles 1..8, idle on cycle 9.
    push_seq(0, 64'b10100101, 8, 8);
    send(0, 64'hA5);
    repeat (8) cyc();
    check("a5_busy_c9", {63'd0, bz_a[0]}, 64'd0);
    check("a5_valid_c9", {63'd0, dv_a[0]}, 64'd0);

    // LSB-first: 8'hA5 then 8'h01 streamed back-to-back.
    push_seq(1, 64'b1010010110000000, 16, 8);
    send(1, 64'hA5);
    send(1, 64'h01);
    repeat (15) cyc();
    check("lsb_busy_end", {63'd0, bz_a[1]}, 64'd0);

    // DATA_W=4 back-to-back: 4'hC, then 4'h3 parked in hold until C drains.
    push_seq(2, 64'b11000011, 8, 4);
    send(2, 64'hC);
    send(2, 64'h3);
    for (int c = 2; c <= 8; c++) begin
      check($sformatf("b2b_valid_c%0d", c), {63'd0, dv_a[2]}, 64'd1);
      check($sformatf("b2b_din_ready_c%0d", c), {63'd0, dr_a[2]}, {63'd0, (c >= 5)});
      cyc();
    end
    check("b2b_busy_c9", {63'd0, bz_a[2]}, 64'd0);

    // Backpressure on cycles 3..6 with 8'hF0.
    push_seq(0, 64'b11110000, 8, 8);
    send(0, 64'hF0);
    cyc();
    cyc();
    rdy_a[0] = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      check($sformatf("bp_hold_c%0d", c), {60'd0, dv_a[0], dd_a[0], df_a[0], dl_a[0]},
            64'b1100);
      cyc();
    end
    rdy_a[0] = 1'b1;
    for (int c = 7; c <= 12; c++) begin
      check($sformatf("bp_last_c%0d", c), {63'd0, dl_a[0]}, {63'd0, (c == 12)});
      cyc();
    end
    check("bp_busy_c13", {63'd0, bz_a[0]}, 64'd0);

    // Reset during bit 3 of 8'hFF with 8'h55 in hold.
    push_seq(0, 64'hFF, 8, 8);
    send(0, 64'hFF);
    send(0, 64'h55);
    check("rst_mid_hold_full", {63'd0, dr_a[0]}, 64'd0);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {59'd0, dv_a[0], dd_a[0], df_a[0], dl_a[0], bz_a[0]}, 64'd0);
    check("rst_mid_din_ready", {63'd0, dr_a[0]}, 64'd1);
    q0.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("post_rst_idle_%0d", c), {62'd0, dv_a[0], bz_a[0]}, 64'd0);
      cyc();
    end
    push_seq(0, 64'b10000001, 8, 8);
    send(0, 64'h81);
    repeat (8) cyc();
    check("post_rst_busy_end", {63'd0, bz_a[0]}, 64'd0);

    // DATA_W=2 corner: 2'b10, 2'b01, 2'b11 offered continuously.
    push_seq(3, 64'b100111, 6, 2);
    for (int c = 0; c < 8; c++) begin
      din_a[3] = {62'd0, u2_din[c]};
      v_a[3]   = u2_v[c];
      check($sformatf("w2_din_ready_c%0d", c), {63'd0, dr_a[3]}, {63'd0, u2_dr[c]});
      check($sformatf("w2_valid_c%0d", c), {63'd0, dv_a[3]}, {63'd0, u2_dv[c]});
      cyc();
    end
    v_a[3] = 1'b0;
    check("w2_busy_end", {63'd0, bz_a[3]}, 64'd0);

    cyc();
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
